// File: rtl/spi_word_engine_if.sv
// Host-side handshake bundle for spi_word_engine: tx holding-register feed and rx FIFO drain.
interface spi_word_engine_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  modport master (output tx_data, tx_valid, rx_ready, input tx_ready, rx_data, rx_valid);
  modport slave  (input tx_data, tx_valid, rx_ready, output tx_ready, rx_data, rx_valid);
endinterface

// File: rtl/spi_word_engine.sv
// SPI word shift engine in the sclk_o domain: tx holding + shift register, rx FIFO, word/frame counting.
// Optional build macro SPI_LOOPBACK_EN adds loopback_i (rx samples internal mosi instead of miso_i).
module spi_word_engine #(
  parameter int DATA_WIDTH  = 8,
  parameter int RX_DEPTH    = 4,
  parameter int MSB_FIRST   = 1,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                          sclk_o,
  input  logic                          rst,
  input  logic                          ncs_o,
  input  logic                          miso_i,
  output logic                          mosi_o,
`ifdef SPI_LOOPBACK_EN
  input  logic                          loopback_i,
`endif
  spi_word_engine_if.slave              host,
  output logic [$clog2(DATA_WIDTH)-1:0] bit_count,
  output logic                          word_begin,
  output logic                          word_done,
  output logic [FRAME_CNT_W-1:0]        frame_words,
  output logic                          tx_underrun,
  output logic                          rx_overflow,
  input  logic                          status_clr
);
  localparam int BCW = $clog2(DATA_WIDTH);
  localparam int AW  = $clog2(RX_DEPTH);
  localparam logic [BCW-1:0]         LAST_BIT = BCW'(DATA_WIDTH - 1);
  localparam logic [AW:0]            FULL_CNT = (AW + 1)'(RX_DEPTH);
  localparam logic [FRAME_CNT_W-1:0] FW_MAX   = {FRAME_CNT_W{1'b1}};

  logic [BCW-1:0]        bit_cnt_r;
  logic [BCW-1:0]        phys_s;
  logic                  word_begin_s;
  logic                  word_done_s;
  logic                  drop_s;
  logic [DATA_WIDTH-1:0] hold_r;
  logic                  hold_vld_r;
  logic [DATA_WIDTH-1:0] cur_r;
  logic                  cur_vld_r;
  logic                  load_s;
  logic                  accept_s;
  logic                  mosi_int_s;
  logic                  rx_bit_s;
  logic [DATA_WIDTH-1:0] rx_shift_r;
  logic [DATA_WIDTH-1:0] rx_word_s;
  logic [DATA_WIDTH-1:0] mem_r [RX_DEPTH];
  logic [AW:0]           wr_ptr_r;
  logic [AW:0]           rd_ptr_r;
  logic [AW:0]           fill_s;
  logic                  empty_s;
  logic                  full_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  ovf_set_s;
  logic                  unr_set_s;
  logic [FRAME_CNT_W-1:0] fw_r;
  logic                  unr_r;
  logic                  ovf_r;

  assign phys_s       = (MSB_FIRST != 0) ? (LAST_BIT - bit_cnt_r) : bit_cnt_r;
  assign word_begin_s = ~ncs_o & (bit_cnt_r == {BCW{1'b0}});
  assign word_done_s  = ~ncs_o & (bit_cnt_r == LAST_BIT);
  // ncs_o seen high with a word part-way through: that word is abandoned.
  assign drop_s       = ncs_o & (bit_cnt_r != {BCW{1'b0}});

  // Holding moves into cur whenever cur is (or is about to become) free.
  assign load_s    = hold_vld_r & (~cur_vld_r | word_done_s | drop_s);
  assign accept_s  = host.tx_valid & host.tx_ready;
  assign unr_set_s = word_begin_s & ~cur_vld_r;

  assign host.tx_ready = ~hold_vld_r | load_s;
  assign mosi_int_s    = cur_vld_r ? cur_r[phys_s] : 1'b1;
  assign mosi_o        = ncs_o ? 1'bz : mosi_int_s;

`ifdef SPI_LOOPBACK_EN
  assign rx_bit_s = loopback_i ? mosi_int_s : miso_i;
`else
  assign rx_bit_s = miso_i;
`endif

  // Word under assembly, including the bit sampled on this edge.
  always_comb begin
    rx_word_s         = rx_shift_r;
    rx_word_s[phys_s] = rx_bit_s;
  end

  assign fill_s    = wr_ptr_r - rd_ptr_r;
  assign empty_s   = (wr_ptr_r == rd_ptr_r);
  assign full_s    = (fill_s == FULL_CNT);
  assign pop_s     = ~empty_s & host.rx_ready;
  assign push_s    = word_done_s & (~full_s | pop_s);
  assign ovf_set_s = word_done_s & full_s & ~pop_s;

  assign host.rx_valid = ~empty_s;
  assign host.rx_data  = empty_s ? {DATA_WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

  assign bit_count   = bit_cnt_r;
  assign word_begin  = word_begin_s;
  assign word_done   = word_done_s;
  assign frame_words = fw_r;
  assign tx_underrun = unr_r;
  assign rx_overflow = ovf_r;

  // Bit position and per-frame word count; ncs_o high restarts both.
  always_ff @(posedge sclk_o or posedge rst) begin
    if (rst) begin
      bit_cnt_r <= {BCW{1'b0}};
      fw_r      <= {FRAME_CNT_W{1'b0}};
    end else if (ncs_o) begin
      bit_cnt_r <= {BCW{1'b0}};
      fw_r      <= {FRAME_CNT_W{1'b0}};
    end else begin
      bit_cnt_r <= word_done_s ? {BCW{1'b0}} : (bit_cnt_r + BCW'(1));
      if (word_done_s && (fw_r != FW_MAX)) begin
        fw_r <= fw_r + FRAME_CNT_W'(1);
      end else begin
        fw_r <= fw_r;
      end
    end
  end

  // TX holding and shift registers.
  always_ff @(posedge sclk_o or posedge rst) begin
    if (rst) begin
      hold_r     <= {DATA_WIDTH{1'b0}};
      hold_vld_r <= 1'b0;
      cur_r      <= {DATA_WIDTH{1'b0}};
      cur_vld_r  <= 1'b0;
    end else begin
      if (load_s) begin
        cur_r     <= hold_r;
        cur_vld_r <= 1'b1;
      end else if (word_done_s || drop_s) begin
        cur_vld_r <= 1'b0;
      end else begin
        cur_vld_r <= cur_vld_r;
      end
      if (accept_s) begin
        hold_r     <= host.tx_data;
        hold_vld_r <= 1'b1;
      end else if (load_s) begin
        hold_vld_r <= 1'b0;
      end else begin
        hold_vld_r <= hold_vld_r;
      end
    end
  end

  // RX shift register and FIFO pointers.
  always_ff @(posedge sclk_o or posedge rst) begin
    if (rst) begin
      rx_shift_r <= {DATA_WIDTH{1'b0}};
      wr_ptr_r   <= {(AW + 1){1'b0}};
      rd_ptr_r   <= {(AW + 1){1'b0}};
    end else begin
      if (!ncs_o) begin
        rx_shift_r <= rx_word_s;
      end else begin
        rx_shift_r <= rx_shift_r;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + (AW + 1)'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW + 1)'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // FIFO storage; contents are only observable through the pointers, so no reset.
  always_ff @(posedge sclk_o) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= rx_word_s;
    end
  end

  // Sticky status; a set event on the same edge outranks status_clr.
  always_ff @(posedge sclk_o or posedge rst) begin
    if (rst) begin
      unr_r <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      if (unr_set_s) begin
        unr_r <= 1'b1;
      end else if (status_clr) begin
        unr_r <= 1'b0;
      end else begin
        unr_r <= unr_r;
      end
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (status_clr) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end
endmodule
